// File: rtl/spi_xfer_pkg.sv
// Shared constants and state encoding for the SPI transaction sequencer.
// Optional watchdog is enabled by defining SPI_XFER_TIMEOUT_EN.
package spi_xfer_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int CS_SETUP_DEF = 4;
  localparam int CS_HOLD_DEF  = 4;
  localparam int TIMEOUT_DEF  = 255;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_SHIFT = ST_SHIFT,
    S_HOLD  = ST_HOLD,
    S_DONE  = ST_DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins; on contention the
// pointer picks the winner and then moves to the requester that lost.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (|req)) begin
      ptr_d = ~grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-3 SPI transaction sequencer driving cs_n/mosi and the SCLK generator start line.
// Define SPI_XFER_TIMEOUT_EN to add a strobe watchdog that aborts a stalled SHIFT.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF
`ifdef SPI_XFER_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              err,
  output logic              sclk_start,
  input  logic              sclk_rd,
  input  logic              sclk_wr,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = $clog2(max2(CS_SETUP, CS_HOLD) + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              armed_q, armed_d;
  logic              owner_q, owner_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              sclk_start_q, sclk_start_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  logic [1:0]        arb_grant;
  logic              arb_adv;
  logic [DATA_W-1:0] wsel;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (arb_adv),
    .grant   (arb_grant)
  );

  assign wsel = arb_grant[1] ? wdata1 : wdata0;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    armed_d      = armed_q;
    owner_d      = owner_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    sclk_start_d = sclk_start_q;
    gnt_d        = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    busy_d       = busy_q;
    arb_adv      = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          arb_adv = 1'b1;
          gnt_d   = arb_grant;
          owner_d = arb_grant[1];
          shreg_d = wsel;
          mosi_d  = wsel[DATA_W-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          sclk_start_d = 1'b1;
          armed_d      = 1'b0;
          bitcnt_d     = '0;
`ifdef SPI_XFER_TIMEOUT_EN
          wd_d         = '0;
`endif
          state_d      = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        // A sample strobe before the first launch sees SCLK still high from idle.
        if (sclk_wr) begin
          mosi_d  = shreg_q[DATA_W-1];
          armed_d = 1'b1;
        end else if (sclk_rd && armed_q) begin
          shreg_d  = {shreg_q[DATA_W-2:0], miso};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
            sclk_start_d = 1'b0;
            cnt_d        = '0;
            state_d      = S_HOLD;
          end
        end
`ifdef SPI_XFER_TIMEOUT_EN
        if (sclk_wr || sclk_rd) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          sclk_start_d = 1'b0;
          cs_n_d       = 1'b1;
          mosi_d       = 1'b1;
          err_d        = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        rsp_rdata_d = shreg_q;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      armed_q      <= 1'b0;
      owner_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b1;
      sclk_start_q <= 1'b0;
      gnt_q        <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      armed_q      <= armed_d;
      owner_q      <= owner_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      sclk_start_q <= sclk_start_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
`ifdef SPI_XFER_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = busy_q;
  assign sclk_start = sclk_start_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural SCLK generator and SPI slave/loopback model.
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, err, sclk_start, sclk_rd, sclk_wr, cs_n, mosi, miso;

  int n_assert = 0;
  int n_fail   = 0;
  int err_seen = 0;

  // Generator / slave model state
  logic       run = 1'b0;
  logic [2:0] ph = 3'd0;
  logic       stall = 1'b0;
  logic       inj_rd = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       miso_reg = 1'b1;
  logic       cs_n_prev = 1'b1;
  logic       sclk;
  int         rise_cnt = 0;
  int         fall_cnt = 0;

  always #5 clk = ~clk;

  spi_xfer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .err        (err),
    .sclk_start (sclk_start),
    .sclk_rd    (sclk_rd),
    .sclk_wr    (sclk_wr),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso)
  );

  // SCLK period = 8 clk: low for ph 0..3 (launch at ph 2), high for ph 4..7 (sample at ph 6)
  assign sclk    = !run || ph[2];
  assign sclk_wr = run && !stall && (ph == 3'd2);
  assign sclk_rd = (run && !stall && (ph == 3'd6)) || inj_rd;
  assign miso    = loop_en ? mosi : miso_reg;

  always @(posedge clk) begin
    cs_n_prev <= cs_n;
    if (err) err_seen <= err_seen + 1;
    if (!sclk_start) begin
      run <= 1'b0;
      ph  <= 3'd0;
    end else if (!stall) begin
      if (!run || ph == 3'd7) begin
        if (fall_cnt < 8) miso_reg <= slave_tx[7 - fall_cnt];
        fall_cnt <= fall_cnt + 1;
      end
      if (run && ph == 3'd3) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], mosi};
      end
      run <= 1'b1;
      ph  <= run ? ph + 3'd1 : 3'd0;
    end
    if (cs_n_prev && !cs_n) begin
      rise_cnt <= 0;
      fall_cnt <= 0;
      mosi_cap <= 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc, output int gseen);
    cyc = 0;
    gseen = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (gnt != 2'b00) gseen++;
    end while (rsp_valid == 2'b00 && cyc < 400);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, gs, rv;
    reset = 1'b1; req = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_mosi", mosi, 1'b1);
    check("rst_sclk_start", sclk_start, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk); reset = 1'b0;

    // 1: requester 0, A5 out, slave returns 3C
    @(negedge clk); wdata0 = 8'hA5; slave_tx = 8'h3C; loop_en = 1'b0; req = 2'b01;
    @(posedge clk); #1;
    check("t1_gnt", gnt, 2'b01);
    check("t1_busy", busy, 1'b1);
    check("t1_cs_n", cs_n, 1'b0);
    check("t1_mosi_msb", mosi, 1'b1);
    req = 2'b00;
    @(posedge clk); #1;
    check("t1_gnt_pulse", gnt, 2'b00);
    n = 1;
    while (!sclk_start && n < 50) begin @(posedge clk); #1; n++; end
    check("t1_setup_cycles", n, 4);
    wait_rsp(n, gs);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rdata", rsp_rdata, 8'h3C);
    check("t1_mosi_bits", mosi_cap, 8'hA5);
    check("t1_rise_cnt", rise_cnt, 8);
    check("t1_busy_done", busy, 1'b0);
    check("t1_cs_n_done", cs_n, 1'b1);
    @(posedge clk); #1;
    check("t1_rsp_pulse", rsp_valid, 2'b00);
    check("t1_rdata_held", rsp_rdata, 8'h3C);

    // 3: requester 1, loopback 81
    @(negedge clk); wdata1 = 8'h81; loop_en = 1'b1; req = 2'b10;
    @(posedge clk); #1;
    check("t3_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_rsp(n, gs);
    check("t3_rsp_valid", rsp_valid, 2'b10);
    check("t3_rdata", rsp_rdata, 8'h81);
    check("t3_mosi_bits", mosi_cap, 8'h81);
    check("t3_rise_cnt", rise_cnt, 8);
    loop_en = 1'b0;

    // 2: contention, round-robin 01 -> 10 -> 01
    @(negedge clk); wdata0 = 8'h11; wdata1 = 8'h22; slave_tx = 8'hE7; req = 2'b11;
    @(posedge clk); #1;
    check("t2a_gnt", gnt, 2'b01);
    req = 2'b10;
    wait_rsp(n, gs);
    check("t2a_no_gnt_busy", gs, 0);
    check("t2a_rsp_valid", rsp_valid, 2'b01);
    check("t2a_rdata", rsp_rdata, 8'hE7);
    check("t2a_mosi_bits", mosi_cap, 8'h11);
    @(posedge clk); #1;
    check("t2b_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_rsp(n, gs);
    check("t2b_rsp_valid", rsp_valid, 2'b10);
    check("t2b_mosi_bits", mosi_cap, 8'h22);
    @(negedge clk); req = 2'b11;
    @(posedge clk); #1;
    check("t2c_gnt", gnt, 2'b01);
    req = 2'b00;
    wait_rsp(n, gs);
    check("t2c_rsp_valid", rsp_valid, 2'b01);

    // 5: stray sample strobe before the first launch
    @(negedge clk); wdata0 = 8'h5A; slave_tx = 8'hC3; req = 2'b01;
    @(posedge clk); #1;
    check("t5_gnt", gnt, 2'b01);
    req = 2'b00;
    n = 0;
    while (!sclk_start && n < 50) begin @(posedge clk); #1; n++; end
    inj_rd = 1'b1;
    @(posedge clk); #1;
    inj_rd = 1'b0;
    wait_rsp(n, gs);
    check("t5_rsp_valid", rsp_valid, 2'b01);
    check("t5_rdata", rsp_rdata, 8'hC3);
    check("t5_mosi_bits", mosi_cap, 8'h5A);
    check("t5_rise_cnt", rise_cnt, 8);

    // 4: reset after the third sample
    @(negedge clk); wdata1 = 8'h0F; slave_tx = 8'hF0; req = 2'b10;
    @(posedge clk); #1;
    check("t4_gnt", gnt, 2'b10);
    req = 2'b00;
    n = 0;
    while (rise_cnt != 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("t4_reach_3", rise_cnt, 3);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("t4_cs_n", cs_n, 1'b1);
    check("t4_sclk_start", sclk_start, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_rsp_valid", rsp_valid, 2'b00);
    @(negedge clk); reset = 1'b0;
    rv = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (rsp_valid != 2'b00) rv++;
    end
    check("t4_no_rsp_after", rv, 0);
    check("t4_idle_busy", busy, 1'b0);

`ifdef SPI_XFER_TIMEOUT_EN
    // 6: stalled strobes trip the watchdog
    @(negedge clk); wdata0 = 8'hFF; req = 2'b01;
    @(posedge clk); #1;
    check("t6_gnt", gnt, 2'b01);
    req = 2'b00;
    n = 0;
    while (!sclk_start && n < 50) begin @(posedge clk); #1; n++; end
    stall = 1'b1;
    n = 0; rv = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid != 2'b00) rv++;
    end while (!err && n < 400);
    check("t6_err_cycles", n, 255);
    check("t6_err", err, 1'b1);
    check("t6_cs_n", cs_n, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_sclk_start", sclk_start, 1'b0);
    check("t6_no_rsp", rv, 0);
    @(posedge clk); #1;
    check("t6_err_pulse", err, 1'b0);
    stall = 1'b0;
`else
    check("no_err_default", err_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
